// File: rtl/led_scan_ctrl.sv
// rtl/led_scan_ctrl.sv - HUB75-style LED panel scan controller with painter query pipeline
//
// Walks a 64x64 panel as 32 row pairs.  For each row pair it queries an
// external painter for every pixel of the upper and lower half, shifts the
// returned colours into the panel, latches them and displays the row.
//
// Parameters
//   DELAY      painter pipeline latency in cycles (1..8)
//   ON_CYCLES  base display time per row in cycles (1..1024)
//
// Configuration macro
//   LED_SCAN_BCM_EN  when defined, display time is ON_CYCLES << subframe[2:0]
//                    (binary-coded modulation); otherwise ON_CYCLES always.
//
// Ports
//   clk       in   1   system clock, rising edge
//   resetn    in   1   asynchronous active-low reset
//   frame     out  10  frame number to painter
//   subframe  out  8   subframe number to painter
//   x         out  6   pixel column query to painter
//   y         out  6   pixel row query to painter
//   rgb       in   3   painter response {B,G,R}, DELAY cycles after its query
//   rgb0      out  3   upper-half pixel data to panel
//   rgb1      out  3   lower-half pixel data to panel
//   sclk      out  1   panel shift clock
//   latch     out  1   panel latch strobe
//   blank     out  1   panel output disable, 1 = dark
//   addr      out  5   panel row-pair address

module led_scan_ctrl #(
    parameter int DELAY     = 3,
    parameter int ON_CYCLES = 64
) (
    input  logic       clk,
    input  logic       resetn,
    output logic [9:0] frame,
    output logic [7:0] subframe,
    output logic [5:0] x,
    output logic [5:0] y,
    input  logic [2:0] rgb,
    output logic [2:0] rgb0,
    output logic [2:0] rgb1,
    output logic       sclk,
    output logic       latch,
    output logic       blank,
    output logic [4:0] addr
);

    typedef enum logic [1:0] {
        ST_SHIFT,
        ST_DRAIN,
        ST_LATCH,
        ST_DISPLAY
    } state_t;

    localparam logic [17:0] ON_LEN     = 18'(ON_CYCLES);
    localparam logic [17:0] DRAIN_LAST = 18'(DELAY);
    localparam logic [17:0] SHIFT_LAST = 18'd127;

    state_t            state;
    logic [17:0]       cnt;        // cycle counter within the current state
    logic [4:0]        row;        // row pair being scanned
    logic [2:0]        hold;       // upper-half colour waiting for its lower partner
    logic [DELAY-1:0]  tag_valid;  // query-was-real flag travelling with each query
    logic [DELAY-1:0]  tag_lower;  // 1 = query addressed the lower half (y = row + 32)
    logic [17:0]       disp_len;
    logic [6:0]        next_q;     // index of the query presented after this cycle

`ifdef LED_SCAN_BCM_EN
    assign disp_len = ON_LEN << subframe[2:0];
`else
    assign disp_len = ON_LEN;
`endif

    assign next_q = cnt[6:0] + 7'd1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_SHIFT;
            cnt       <= '0;
            row       <= '0;
            hold      <= '0;
            tag_valid <= '0;
            tag_lower <= '0;
            frame     <= '0;
            subframe  <= '0;
            x         <= '0;
            y         <= '0;
            rgb0      <= '0;
            rgb1      <= '0;
            sclk      <= 1'b0;
            latch     <= 1'b0;
            blank     <= 1'b1;
            addr      <= '0;
        end else begin
            // Tag pipeline: stage 0 describes the query presented this cycle,
            // stage DELAY-1 describes the query whose answer is on rgb now.
            tag_valid[0] <= (state == ST_SHIFT);
            tag_lower[0] <= cnt[0];
            for (int i = 1; i < DELAY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_lower[i] <= tag_lower[i-1];
            end

            // Returning responses: upper half parks in hold, lower half pushes
            // the pixel pair to the panel together with a one-cycle sclk.
            sclk <= 1'b0;
            if (tag_valid[DELAY-1]) begin
                if (tag_lower[DELAY-1]) begin
                    rgb0 <= hold;
                    rgb1 <= rgb;
                    sclk <= 1'b1;
                end else begin
                    hold <= rgb;
                end
            end

            case (state)
                ST_SHIFT: begin
                    // Query 2c is (c, row), query 2c+1 is (c, row+32).
                    if (cnt == SHIFT_LAST) begin
                        state <= ST_DRAIN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 18'd1;
                        x   <= next_q[6:1];
                        y   <= {next_q[0], row};
                    end
                end

                ST_DRAIN: begin
                    // x/y hold their last value while the final responses land.
                    if (cnt == DRAIN_LAST) begin
                        state <= ST_LATCH;
                        cnt   <= '0;
                        latch <= 1'b1;
                        addr  <= row;
                    end else begin
                        cnt <= cnt + 18'd1;
                    end
                end

                ST_LATCH: begin
                    state <= ST_DISPLAY;
                    cnt   <= '0;
                    latch <= 1'b0;
                    blank <= 1'b0;
                end

                ST_DISPLAY: begin
                    if (cnt == disp_len - 18'd1) begin
                        state <= ST_SHIFT;
                        cnt   <= '0;
                        blank <= 1'b1;
                        row   <= row + 5'd1;
                        x     <= '0;
                        y     <= {1'b0, row + 5'd1};
                        // Frame counters only move between rows so every query
                        // of a row sees the same frame/subframe.
                        if (row == 5'd31) begin
                            subframe <= subframe + 8'd1;
                            if (subframe == 8'd255) begin
                                frame <= frame + 10'd1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 18'd1;
                    end
                end

                default: begin
                    state <= ST_SHIFT;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// tb/tb_led_scan_ctrl.sv - self-checking bench for led_scan_ctrl
`timescale 1ns/1ps
module tb_led_scan_ctrl;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Painter image: img[y][x] = {B,G,R}
    logic [2:0] img [64][64];

    // Instance d3: DELAY 3, d1: DELAY 1, d8: DELAY 8 (all ON_CYCLES 64); bm: DELAY 3, ON_CYCLES 4
    logic [9:0] fr3, fr1, fr8, frb;
    logic [7:0] sf3, sf1, sf8, sfb;
    logic [5:0] x3, x1, x8, xb, y3, y1, y8, yb;
    logic [2:0] rgb3, rgb1, rgb8, rgbb;
    logic [2:0] p0_3, p0_1, p0_8, p0_b, p1_3, p1_1, p1_8, p1_b;
    logic       sck3, sck1, sck8, sckb, lat3, lat1, lat8, latb, blk3, blk1, blk8, blkb;
    logic [4:0] ad3, ad1, ad8, adb;

    led_scan_ctrl #(.DELAY(3), .ON_CYCLES(64)) u_d3 (
        .clk(clk), .resetn(resetn), .frame(fr3), .subframe(sf3), .x(x3), .y(y3),
        .rgb(rgb3), .rgb0(p0_3), .rgb1(p1_3), .sclk(sck3), .latch(lat3), .blank(blk3), .addr(ad3));
    led_scan_ctrl #(.DELAY(1), .ON_CYCLES(64)) u_d1 (
        .clk(clk), .resetn(resetn), .frame(fr1), .subframe(sf1), .x(x1), .y(y1),
        .rgb(rgb1), .rgb0(p0_1), .rgb1(p1_1), .sclk(sck1), .latch(lat1), .blank(blk1), .addr(ad1));
    led_scan_ctrl #(.DELAY(8), .ON_CYCLES(64)) u_d8 (
        .clk(clk), .resetn(resetn), .frame(fr8), .subframe(sf8), .x(x8), .y(y8),
        .rgb(rgb8), .rgb0(p0_8), .rgb1(p1_8), .sclk(sck8), .latch(lat8), .blank(blk8), .addr(ad8));
    led_scan_ctrl #(.DELAY(3), .ON_CYCLES(4)) u_bm (
        .clk(clk), .resetn(resetn), .frame(frb), .subframe(sfb), .x(xb), .y(yb),
        .rgb(rgbb), .rgb0(p0_b), .rgb1(p1_b), .sclk(sckb), .latch(latb), .blank(blkb), .addr(adb));

    // Painter models: answer img[y][x] exactly DELAY cycles after the query.
    logic [2:0] pp3 [8], pp1 [8], pp8 [8], ppb [8];
    always @(posedge clk) begin
        pp3[0] <= img[y3][x3];
        pp1[0] <= img[y1][x1];
        pp8[0] <= img[y8][x8];
        ppb[0] <= img[yb][xb];
        for (int i = 1; i < 8; i++) begin
            pp3[i] <= pp3[i-1];
            pp1[i] <= pp1[i-1];
            pp8[i] <= pp8[i-1];
            ppb[i] <= ppb[i-1];
        end
    end
    assign rgb3 = pp3[2];
    assign rgb1 = pp1[0];
    assign rgb8 = pp8[7];
    assign rgbb = ppb[2];

    // Panel-side capture: every sclk-high cycle records the shifted pixel pair.
    logic [5:0] q [3][$];
    always @(negedge clk) begin
        if (sck3) q[0].push_back({p0_3, p1_3});
        if (sck1) q[1].push_back({p0_1, p1_1});
        if (sck8) q[2].push_back({p0_8, p1_8});
    end

    localparam logic [43:0] RST_VEC = {10'd0, 8'd0, 6'd0, 6'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 5'd0};
    logic [43:0] ob3, ob1, ob8, obb;
    assign ob3 = {fr3, sf3, x3, y3, p0_3, p1_3, sck3, lat3, blk3, ad3};
    assign ob1 = {fr1, sf1, x1, y1, p0_1, p1_1, sck1, lat1, blk1, ad1};
    assign ob8 = {fr8, sf8, x8, y8, p0_8, p1_8, sck8, lat8, blk8, ad8};
    assign obb = {frb, sfb, xb, yb, p0_b, p1_b, sckb, latb, blkb, adb};

    // Reference: k-th shifted pair since reset is column k%64 of row pair (k/64)%32.
    function automatic logic [5:0] exp_pulse(int k);
        int r;
        int c;
        r = (k / 64) % 32;
        c = k % 64;
        return {img[r][c], img[r+32][c]};
    endfunction

    int exp_row = 0;

    task automatic apply_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) q[i].delete();
    endtask

    task automatic release_reset();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        #2 resetn = 1'b0;
        #1;
        for (int pass = 0; pass < 2; pass++) begin
            checks++; if (ob3 !== RST_VEC) begin errors++; $display("FAIL reset_d3 pass%0d got %h want %h", pass, ob3, RST_VEC); end
            checks++; if (ob1 !== RST_VEC) begin errors++; $display("FAIL reset_d1 pass%0d got %h want %h", pass, ob1, RST_VEC); end
            checks++; if (ob8 !== RST_VEC) begin errors++; $display("FAIL reset_d8 pass%0d got %h want %h", pass, ob8, RST_VEC); end
            checks++; if (obb !== RST_VEC) begin errors++; $display("FAIL reset_bm pass%0d got %h want %h", pass, obb, RST_VEC); end
            repeat (3) @(negedge clk);
        end
        for (int i = 0; i < 3; i++) q[i].delete();
    endtask

    task automatic test_pattern();
        int n;
        logic [5:0] got;
        logic [5:0] want;
        logic [5:0] cv;
        for (int yy = 0; yy < 64; yy++)
            for (int xx = 0; xx < 64; xx++) begin
                cv = 6'(xx);
                img[yy][xx] = {(yy == 32), cv[0], ~cv[0]};
            end
        release_reset();
        n = 0;
        while ((q[0].size() < 64 || q[1].size() < 64 || q[2].size() < 64) && n < 400) begin
            @(negedge clk);
            n++;
        end
        for (int inst = 0; inst < 3; inst++)
            for (int c = 0; c < 64; c++) begin
                cv   = 6'(c);
                want = {1'b0, cv[0], ~cv[0], 1'b1, cv[0], ~cv[0]};
                got  = (c < q[inst].size()) ? q[inst][c] : 6'bx;
                checks++;
                if (got !== want) begin errors++; $display("FAIL pattern inst%0d col%0d got %h want %h", inst, c, got, want); end
            end
    endtask

    task automatic test_row_timing();
        int t3 = -1, t3b = -1, t1 = -1, t8 = -1;
        int n3 = 0, n3b = 0, n1 = 0, n8 = 0, bad = 0, low3 = 0;
        logic [4:0] a0 = 5'h1f, a1 = 5'h1f;
        apply_reset();
        for (int yy = 0; yy < 64; yy++)
            for (int xx = 0; xx < 64; xx++) img[yy][xx] = 3'($urandom);
        release_reset();
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (lat3 && t3 < 0) begin t3 = n; n3 = q[0].size(); a0 = ad3; end
            else if (lat3 && t3b < 0) begin t3b = n; n3b = q[0].size(); a1 = ad3; end
            if (lat1 && t1 < 0) begin t1 = n; n1 = q[1].size(); end
            if (lat8 && t8 < 0) begin t8 = n; n8 = q[2].size(); end
            if ((t3 < 0 || t3 == n) && !blk3) bad++;
            if (t3 >= 0 && t3b < 0 && !blk3) low3++;
        end
        // Latch after 128 shift + DELAY+1 drain cycles; row = 128 + DELAY+1 + 1 + 64 cycles.
        checks++; if (t3 != 132) begin errors++; $display("FAIL latch_pos_d3 got %0d want 132", t3); end
        checks++; if (t1 != 130) begin errors++; $display("FAIL latch_pos_d1 got %0d want 130", t1); end
        checks++; if (t8 != 137) begin errors++; $display("FAIL latch_pos_d8 got %0d want 137", t8); end
        checks++; if (n3 != 64) begin errors++; $display("FAIL sclk_count_d3 got %0d want 64", n3); end
        checks++; if (n1 != 64) begin errors++; $display("FAIL sclk_count_d1 got %0d want 64", n1); end
        checks++; if (n8 != 64) begin errors++; $display("FAIL sclk_count_d8 got %0d want 64", n8); end
        checks++; if (bad != 0) begin errors++; $display("FAIL blank_before_display got %0d dark-off cycles want 0", bad); end
        checks++; if (low3 != 64) begin errors++; $display("FAIL display_len got %0d want 64", low3); end
        checks++; if (a0 !== 5'd0) begin errors++; $display("FAIL addr_row0 got %0d want 0", a0); end
        checks++; if (t3b != 329) begin errors++; $display("FAIL latch_pos_row1 got %0d want 329", t3b); end
        checks++; if (a1 !== 5'd1) begin errors++; $display("FAIL addr_row1 got %0d want 1", a1); end
        checks++; if (n3b != 128) begin errors++; $display("FAIL sclk_count_row1 got %0d want 128", n3b); end
        exp_row = 2;
    endtask

    task automatic test_row_wrap();
        logic [7:0] prev_sf;
        logic       prev_blk;
        logic [4:0] last_addr = 5'd0;
        logic [5:0] got;
        int         found = 0;
        int         size_at = 0;
        prev_sf  = sf3;
        prev_blk = blk3;
        for (int n = 0; n < 7000 && found == 0; n++) begin
            @(negedge clk);
            if (lat3) begin
                checks++;
                if (ad3 !== 5'(exp_row)) begin errors++; $display("FAIL addr_seq got %0d want %0d", ad3, exp_row); end
                exp_row   = (exp_row + 1) % 32;
                last_addr = ad3;
            end
            if (sf3 !== prev_sf) begin
                found   = 1;
                size_at = q[0].size();
                checks++; if (prev_sf !== 8'd0 || sf3 !== 8'd1) begin errors++; $display("FAIL subframe_step got %0d->%0d want 0->1", prev_sf, sf3); end
                checks++; if (prev_blk !== 1'b0 || blk3 !== 1'b1) begin errors++; $display("FAIL subframe_edge blank got %b->%b want 0->1", prev_blk, blk3); end
                checks++; if (x3 !== 6'd0 || y3 !== 6'd0) begin errors++; $display("FAIL row_wrap xy got %0d,%0d want 0,0", x3, y3); end
                checks++; if (last_addr !== 5'd31) begin errors++; $display("FAIL row_wrap last_addr got %0d want 31", last_addr); end
                checks++; if (fr3 !== 10'd0) begin errors++; $display("FAIL row_wrap frame got %0d want 0", fr3); end
            end
            prev_sf  = sf3;
            prev_blk = blk3;
        end
        checks++; if (found == 0) begin errors++; $display("FAIL row_wrap timeout got 0 want 1"); end
        checks++; if (size_at != 2048) begin errors++; $display("FAIL pulses_per_subframe got %0d want 2048", size_at); end
        for (int inst = 0; inst < 3; inst++)
            for (int k = 0; k < q[inst].size(); k++) begin
                got = q[inst][k];
                checks++;
                if (got !== exp_pulse(k)) begin errors++; $display("FAIL data inst%0d pulse%0d got %h want %h", inst, k, got, exp_pulse(k)); end
            end
    endtask

    task automatic test_frame_wrap();
        logic [7:0] prev_sf;
        logic [9:0] prev_fr;
        logic       prev_blk;
        int         n = 0;
        int         done = 0;
        while (blk3 && n < 400) begin @(negedge clk); n++; end
        force u_d3.row = 5'd31;
        force u_d3.subframe = 8'd255;
        force u_d3.frame = 10'd1023;
        #1;
        release u_d3.row;
        release u_d3.subframe;
        release u_d3.frame;
        prev_sf  = sf3;
        prev_fr  = fr3;
        prev_blk = blk3;
        for (int i = 0; i < 9000 && done == 0; i++) begin
            @(negedge clk);
            if (prev_blk === 1'b0 && blk3 === 1'b1) begin
                done = 1;
                checks++; if (prev_sf !== 8'd255 || sf3 !== 8'd0) begin errors++; $display("FAIL subframe_wrap got %0d->%0d want 255->0", prev_sf, sf3); end
                checks++; if (prev_fr !== 10'd1023 || fr3 !== 10'd0) begin errors++; $display("FAIL frame_wrap got %0d->%0d want 1023->0", prev_fr, fr3); end
                checks++; if (y3 !== 6'd0) begin errors++; $display("FAIL frame_wrap row got %0d want 0", y3); end
            end
            prev_sf  = sf3;
            prev_fr  = fr3;
            prev_blk = blk3;
        end
        checks++; if (done == 0) begin errors++; $display("FAIL frame_wrap timeout got 0 want 1"); end
    endtask

    task automatic test_reset_mid_shift();
        int n = 0;
        int t3 = -1;
        int n3 = 0;
        logic [5:0] got;
        while (!(sck3 && x3 < 6'd40) && n < 600) begin @(negedge clk); n++; end
        checks++; if (n >= 600) begin errors++; $display("FAIL mid_shift_wait got timeout want sclk in shift"); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (ob3 !== RST_VEC) begin errors++; $display("FAIL mid_shift_reset got %h want %h", ob3, RST_VEC); end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) q[i].delete();
        release_reset();
        for (int i = 1; i <= 400 && t3 < 0; i++) begin
            @(negedge clk);
            if (lat3) begin t3 = i; n3 = q[0].size(); end
        end
        checks++; if (t3 != 132) begin errors++; $display("FAIL restart_latch got %0d want 132", t3); end
        checks++; if (n3 != 64) begin errors++; $display("FAIL restart_sclk got %0d want 64", n3); end
        for (int k = 0; k < 64; k++) begin
            got = (k < q[0].size()) ? q[0][k] : 6'bx;
            checks++;
            if (got !== exp_pulse(k)) begin errors++; $display("FAIL restart_data pulse%0d got %h want %h", k, got, exp_pulse(k)); end
        end
    endtask

    task automatic test_bcm();
        int low = 0;
        int expd;
        int done = 0;
        logic [7:0] sfp = 8'd0;
        apply_reset();
        release_reset();
        for (int n = 0; n < 16000 && done == 0; n++) begin
            @(negedge clk);
            if (!blkb) begin
                low++;
                sfp = sfb;
            end else if (low > 0) begin
`ifdef LED_SCAN_BCM_EN
                expd = 4 << sfp[2:0];
`else
                expd = 4;
`endif
                checks++;
                if (low != expd) begin errors++; $display("FAIL display_len_sf%0d got %0d want %0d", sfp, low, expd); end
                if (sfp == 8'd3) done = 1;
                low = 0;
            end
        end
        checks++; if (done == 0) begin errors++; $display("FAIL bcm_timeout got 0 want 1"); end
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_row_timing();
        test_row_wrap();
        test_frame_wrap();
        test_reset_mid_shift();
        test_bcm();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
